// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake and holds it in the instruction register until retired.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        ct_branch,
    input  logic        ct_jump,
    input  logic        alu_zero,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  ct_inst,
    output logic [5:0]  aluct_inst,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] br_off_s;
    logic [31:0] next_pc_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign br_off_s   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    // Next-PC select: jump has priority over a taken branch.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (ct_jump) begin
            next_pc_s = {pc_plus4_s[31:28], inst_q[25:0], 2'b00};
        end else if (ct_branch && alu_zero) begin
            next_pc_s = pc_plus4_s + br_off_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Fetch FSM next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = S_VALID;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                if (!stall_in) begin
                    pc_d    = {next_pc_s[31:2], 2'b00};
                    ret_d   = ret_q + 32'd1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_VALID;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, PC, instruction and retire-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ret_q   <= ret_d;
        end
    end

    // Handshake outputs decode from the state register only, so reset drops them at once.
    assign imem_req    = (state_q == S_FETCH);
    assign inst_valid  = (state_q == S_VALID);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign ct_inst     = inst_q[31:26];
    assign aluct_inst  = inst_q[5:0];
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign retired_cnt = ret_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized instruction stream,
// checked against a PC/retire model computed from the architectural rules.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall_in = 1'b0;
    logic        ct_branch = 1'b0;
    logic        ct_jump = 1'b0;
    logic        alu_zero = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  ct_inst;
    logic [5:0]  aluct_inst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retired_cnt;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ret = 32'd0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_in(stall_in), .ct_branch(ct_branch), .ct_jump(ct_jump),
        .alu_zero(alu_zero), .inst_valid(inst_valid), .inst(inst),
        .ct_inst(ct_inst), .aluct_inst(aluct_inst), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule written as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = pc + 32'd4;
        off = {{16{w[15]}}, w[15:0]};
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
        if (b && z) return p4 + off * 32'd4;
        return p4;
    endfunction

    // One full instruction: enter at a negedge in FETCH, leave at a negedge in the next FETCH.
    task automatic run_instr(input logic [31:0] w, input int waits, input int stalls,
                             input logic j, input logic b, input logic z);
        int t0;
        t0 = cyc;
        chk("req_fetch", {31'd0, imem_req}, 32'd1);
        chk("addr_fetch", imem_addr, m_pc);
        chk("ivalid_fetch", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < waits; k++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom();
            @(posedge clk); @(negedge clk);
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(posedge clk); @(negedge clk);
        chk("ivalid", {31'd0, inst_valid}, 32'd1);
        chk("req_valid", {31'd0, imem_req}, 32'd0);
        chk("inst", inst, w);
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("ct_inst", {26'd0, ct_inst}, {26'd0, w[31:26]});
        chk("aluct_inst", {26'd0, aluct_inst}, {26'd0, w[5:0]});
        chk("retired", retired_cnt, m_ret);
        for (int k = 0; k < stalls; k++) begin
            stall_in   = 1'b1;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            @(posedge clk); @(negedge clk);
            chk("ivalid_stall", {31'd0, inst_valid}, 32'd1);
            chk("inst_stall", inst, w);
            chk("pc_stall", pc_out, m_pc);
        end
        stall_in   = 1'b0;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom();
        ct_jump    = j;
        ct_branch  = b;
        alu_zero   = z;
        @(posedge clk); @(negedge clk);
        imem_ack  = 1'b0;
        ct_jump   = 1'b0;
        ct_branch = 1'b0;
        alu_zero  = 1'b0;
        m_pc  = model_next(m_pc, w, j, b, z);
        m_ret = m_ret + 32'd1;
        chk("req_next", {31'd0, imem_req}, 32'd1);
        chk("addr_next", imem_addr, m_pc);
        chk("retired_next", retired_cnt, m_ret);
        chk("latency", 32'(cyc - t0), 32'(2 + waits + stalls));
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        logic        j, b, z;

        // Reset values and first fetch
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ivalid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_ret", retired_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        // Sequential zero-wait addiu stream
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            run_instr({6'b001001, r[25:0]}, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        chk("seq_ret4", retired_cnt, 32'd4);
        chk("seq_addr10", imem_addr, 32'h0000_0010);

        // Taken backward branch at 0x10
        run_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("beq_taken", imem_addr, 32'h0000_000C);

        // Wait states and stall at 0x0C
        r = $urandom();
        run_instr({6'b001001, r[25:0]}, 2, 2, 1'b0, 1'b0, 1'b0);
        chk("ws_addr", imem_addr, 32'h0000_0010);

        // Not-taken branch at 0x10
        run_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("beq_not_taken", imem_addr, 32'h0000_0014);

        // Climb to 0x1000_0040 with two jumps, then jump with branch also asserted
        run_instr({6'b000010, 26'h3FF_FFFF}, 1, 0, 1'b1, 1'b0, 1'b0);
        chk("jmp_a", imem_addr, 32'h0FFF_FFFC);
        run_instr({6'b000010, 26'h000_0010}, 0, 1, 1'b1, 1'b0, 1'b0);
        chk("jmp_b", imem_addr, 32'h1000_0040);
        run_instr(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1);
        chk("jmp_prio", imem_addr, 32'h1000_0400);

        // Reset during FETCH, late ack while and just after reset
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc_out, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_ret", retired_cnt, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_hold", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        chk("late_ack_addr", imem_addr, 32'd0);
        chk("late_ack_ivalid", {31'd0, inst_valid}, 32'd0);
        chk("late_ack_inst", inst, 32'd0);
        m_pc  = 32'd0;
        m_ret = 32'd0;

        // Wrap: branch back from 0 to FFFF_FFFC, then sequential to 0
        run_instr({6'b000100, 5'd3, 5'd3, 16'hFFFE}, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        r = $urandom();
        run_instr({6'b001001, r[25:0]}, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_zero", imem_addr, 32'h0000_0000);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            r = $urandom();
            case ($urandom_range(0, 3))
                0:       op = 6'b000010;
                1:       op = 6'b000100;
                default: op = 6'b001001;
            endcase
            j = (op == 6'b000010);
            b = (op == 6'b000100);
            if ($urandom_range(0, 9) == 0) begin
                j = 1'b1;
                b = 1'b1;
            end
            z = 1'($urandom_range(0, 1));
            run_instr({op, r[25:0]}, $urandom_range(0, 3), $urandom_range(0, 3), j, b, z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
